// File: rtl/ltpi_i2c_event_sched_pkg.sv
// rtl/ltpi_i2c_event_sched_pkg.sv - shared types and constants for the LTPI I2C event scheduler
package ltpi_i2c_event_sched_pkg;

    localparam int I2C_EV_W = 4;
    localparam logic [I2C_EV_W-1:0] I2C_EV_NONE = 4'h0;

    typedef struct packed {
        logic                vld;
        logic [2:0]          ch;
        logic [I2C_EV_W-1:0] ev;
    } i2c_sched_slot_t;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } sched_state_e;

    // Next round-robin start index after idx, wrapping at n channels.
    function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
        return ((int'(idx) + 1) >= n) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/ltpi_i2c_event_sched_if.sv
// rtl/ltpi_i2c_event_sched_if.sv - frame request / slot result interface to the TX builder
interface ltpi_i2c_event_sched_if #(
    parameter int NUM_SLOTS = 2
);
    import ltpi_i2c_event_sched_pkg::*;

    logic                                 frm_req;
    logic                                 frm_done;
    logic [NUM_SLOTS-1:0]                 slot_vld;
    logic [NUM_SLOTS-1:0][2:0]            slot_ch;
    logic [NUM_SLOTS-1:0][I2C_EV_W-1:0]   slot_ev;

    modport master (output frm_req, input frm_done, slot_vld, slot_ch, slot_ev);
    modport slave  (input frm_req, output frm_done, slot_vld, slot_ch, slot_ev);

endinterface

// File: rtl/ltpi_rr_multigrant.sv
// rtl/ltpi_rr_multigrant.sv - rotating-priority scan returning up to NUM_SLOTS grants
module ltpi_rr_multigrant #(
    parameter int NUM_CH    = 6,
    parameter int NUM_SLOTS = 2
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [2:0]                ptr,
    output logic [NUM_SLOTS-1:0]      gnt_vld,
    output logic [NUM_SLOTS-1:0][2:0] gnt_idx,
    output logic [NUM_CH-1:0]         gnt_mask,
    output logic                      any_gnt,
    output logic [2:0]                last_idx
);

    always_comb begin : p_scan
        int cnt;
        int idx;
        gnt_vld  = '0;
        gnt_idx  = '0;
        gnt_mask = '0;
        any_gnt  = 1'b0;
        last_idx = 3'd0;
        cnt      = 0;
        idx      = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if ((c == idx) && req[c] && (cnt < NUM_SLOTS)) begin
                    for (int s = 0; s < NUM_SLOTS; s++) begin
                        if (s == cnt) begin
                            gnt_vld[s] = 1'b1;
                            gnt_idx[s] = 3'(c);
                        end
                    end
                    gnt_mask[c] = 1'b1;
                    last_idx    = 3'(c);
                    any_gnt     = 1'b1;
                    cnt         = cnt + 1;
                end
            end
        end
    end

endmodule

// File: rtl/ltpi_i2c_event_sched.sv
// rtl/ltpi_i2c_event_sched.sv - round-robin I2C event slot scheduler for LTPI operational frames
// Optional per-channel grant/overflow counters when LTPI_I2C_SCHED_STATS_EN is defined.
module ltpi_i2c_event_sched
    import ltpi_i2c_event_sched_pkg::*;
#(
    parameter int NUM_CH    = 6,
    parameter int NUM_SLOTS = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             link_op,
    input  logic [NUM_CH-1:0]                ch_en,
    input  logic [NUM_CH-1:0][I2C_EV_W-1:0]  ev_in,
    input  logic                             ovf_clr,
    ltpi_i2c_event_sched_if.slave            frm,
    output logic [NUM_CH-1:0]                pending,
    output logic [NUM_CH-1:0]                ovf
`ifdef LTPI_I2C_SCHED_STATS_EN
    ,
    output logic [NUM_CH-1:0][15:0]          grant_cnt,
    output logic [NUM_CH-1:0][15:0]          ovf_cnt
`endif
);

    sched_state_e                     state_q, state_d;
    logic [NUM_CH-1:0][I2C_EV_W-1:0]  hold_q, hold_d;
    logic [NUM_CH-1:0]                pend_q, pend_d;
    logic [NUM_CH-1:0]                ovf_q, ovf_d;
    logic [NUM_CH-1:0]                ovf_set;
    logic [2:0]                       rr_q, rr_d;
    logic                             done_q, done_d;
    i2c_sched_slot_t [NUM_SLOTS-1:0]  slot_q, slot_d;

    logic                             run_act;
    logic                             grant_fire;
    logic [NUM_SLOTS-1:0]             gnt_vld;
    logic [NUM_SLOTS-1:0][2:0]        gnt_idx;
    logic [NUM_CH-1:0]                gnt_mask;
    logic                             any_gnt;
    logic [2:0]                       last_idx;

    ltpi_rr_multigrant #(
        .NUM_CH    (NUM_CH),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_rr (
        .req      (pend_q),
        .ptr      (rr_q),
        .gnt_vld  (gnt_vld),
        .gnt_idx  (gnt_idx),
        .gnt_mask (gnt_mask),
        .any_gnt  (any_gnt),
        .last_idx (last_idx)
    );

    // Only a RUN cycle with the link still operational captures or grants.
    assign run_act    = (state_q == ST_RUN) && link_op;
    assign grant_fire = frm.frm_req && run_act;

    always_comb begin
        state_d = link_op ? ST_RUN : ST_FLUSH;
        hold_d  = hold_q;
        pend_d  = pend_q;
        ovf_set = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!run_act || !ch_en[c]) begin
                pend_d[c] = 1'b0;
            end else if ((ev_in[c] != I2C_EV_NONE) && (!pend_q[c] || (grant_fire && gnt_mask[c]))) begin
                hold_d[c] = ev_in[c];
                pend_d[c] = 1'b1;
            end else begin
                if (ev_in[c] != I2C_EV_NONE) begin
                    ovf_set[c] = 1'b1;
                end
                if (grant_fire && gnt_mask[c]) begin
                    pend_d[c] = 1'b0;
                end
            end
        end
        ovf_d  = (ovf_q & {NUM_CH{~ovf_clr}}) | ovf_set;
        rr_d   = (grant_fire && any_gnt) ? rr_next(last_idx, NUM_CH) : rr_q;
        done_d = frm.frm_req;
        slot_d = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (grant_fire && gnt_vld[s]) begin
                slot_d[s].vld = 1'b1;
                slot_d[s].ch  = gnt_idx[s];
                for (int c = 0; c < NUM_CH; c++) begin
                    if (gnt_idx[s] == 3'(c)) begin
                        slot_d[s].ev = hold_q[c];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FLUSH;
            hold_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
            rr_q    <= 3'd0;
            done_q  <= 1'b0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            rr_q    <= rr_d;
            done_q  <= done_d;
            slot_q  <= slot_d;
        end
    end

    assign pending      = pend_q;
    assign ovf          = ovf_q;
    assign frm.frm_done = done_q;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        assign frm.slot_vld[s] = slot_q[s].vld;
        assign frm.slot_ch[s]  = slot_q[s].ch;
        assign frm.slot_ev[s]  = slot_q[s].ev;
    end

`ifdef LTPI_I2C_SCHED_STATS_EN
    logic [NUM_CH-1:0][15:0] grant_cnt_q, grant_cnt_d;
    logic [NUM_CH-1:0][15:0] ovf_cnt_q, ovf_cnt_d;

    // Counters saturate; an overflow coinciding with ovf_clr restarts the count at one.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_fire && gnt_mask[c] && (grant_cnt_q[c] != 16'hFFFF)) begin
                grant_cnt_d[c] = grant_cnt_q[c] + 16'd1;
            end
            if (ovf_clr) begin
                ovf_cnt_d[c] = {15'd0, ovf_set[c]};
            end else if (ovf_set[c] && (ovf_cnt_q[c] != 16'hFFFF)) begin
                ovf_cnt_d[c] = ovf_cnt_q[c] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt_q <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign ovf_cnt   = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_ltpi_i2c_event_sched.sv
// tb/tb_ltpi_i2c_event_sched.sv - scoreboard bench for ltpi_i2c_event_sched
module tb_ltpi_i2c_event_sched;

    localparam int NUM_CH    = 6;
    localparam int NUM_SLOTS = 2;

    typedef struct {
        logic [1:0] vld;
        logic [2:0] ch0;
        logic [3:0] ev0;
        logic [2:0] ch1;
        logic [3:0] ev1;
    } exp_t;

    logic                      clk;
    logic                      reset;
    logic                      link_op;
    logic [NUM_CH-1:0]         ch_en;
    logic [NUM_CH-1:0][3:0]    ev_in;
    logic                      ovf_clr;
    logic [NUM_CH-1:0]         pending;
    logic [NUM_CH-1:0]         ovf;
`ifdef LTPI_I2C_SCHED_STATS_EN
    logic [NUM_CH-1:0][15:0]   grant_cnt;
    logic [NUM_CH-1:0][15:0]   ovf_cnt;
`endif

    int   n_chk;
    int   n_pass;
    exp_t sb[$];

    ltpi_i2c_event_sched_if #(.NUM_SLOTS(NUM_SLOTS)) frm ();

    ltpi_i2c_event_sched #(
        .NUM_CH    (NUM_CH),
        .NUM_SLOTS (NUM_SLOTS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .link_op   (link_op),
        .ch_en     (ch_en),
        .ev_in     (ev_in),
        .ovf_clr   (ovf_clr),
        .frm       (frm.slave),
        .pending   (pending),
        .ovf       (ovf)
`ifdef LTPI_I2C_SCHED_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .ovf_cnt   (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] v, input int c0, input int e0, input int c1, input int e1);
        exp_t e;
        e.vld = v;
        e.ch0 = 3'(c0);
        e.ev0 = 4'(e0);
        e.ch1 = 3'(c1);
        e.ev1 = 4'(e1);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input exp_t e);
        sb.push_back(e);
        frm.frm_req = 1'b1;
        tick();
        frm.frm_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && frm.frm_done) begin
            if (sb.size() == 0) begin
                chk("unexp_done", {31'd0, frm.frm_done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("slot_vld", {30'd0, frm.slot_vld}, {30'd0, e.vld});
                chk("slot0_ch", {29'd0, frm.slot_ch[0]}, {29'd0, e.ch0});
                chk("slot0_ev", {28'd0, frm.slot_ev[0]}, {28'd0, e.ev0});
                chk("slot1_ch", {29'd0, frm.slot_ch[1]}, {29'd0, e.ch1});
                chk("slot1_ev", {28'd0, frm.slot_ev[1]}, {28'd0, e.ev1});
            end
        end
    end

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        reset       = 1'b1;
        link_op     = 1'b0;
        ch_en       = '0;
        ev_in       = '0;
        ovf_clr     = 1'b0;
        frm.frm_req = 1'b0;
        tick();
        tick();
        chk("rst_done", {31'd0, frm.frm_done}, 32'd0);
        chk("rst_vld", {30'd0, frm.slot_vld}, 32'd0);
        chk("rst_pending", {26'd0, pending}, 32'd0);
        chk("rst_ovf", {26'd0, ovf}, 32'd0);
        reset = 1'b0;
        tick();

        // Request while flushing still answers, with empty slots.
        req(mk(2'b00, 0, 0, 0, 0));
        link_op = 1'b1;
        ch_en   = 6'h3F;
        tick();

        // Fairness: all channels pending, three back-to-back requests.
        for (int c = 0; c < NUM_CH; c++) ev_in[c] = 4'(c + 1);
        tick();
        ev_in = '0;
        chk("fair_pend", {26'd0, pending}, 32'h3F);
        req(mk(2'b11, 0, 1, 1, 2));
        req(mk(2'b11, 2, 3, 3, 4));
        req(mk(2'b11, 4, 5, 5, 6));
        chk("fair_empty", {26'd0, pending}, 32'd0);

        // Single event on channel 3.
        ev_in[3] = 4'h5;
        tick();
        ev_in = '0;
        chk("single_pend", {26'd0, pending}, 32'h08);
        tick();
        tick();
        req(mk(2'b01, 3, 5, 0, 0));
        chk("single_clr", {26'd0, pending}, 32'd0);

        // Pointer now at 4: channel 5 precedes channel 1.
        ev_in[1] = 4'hB;
        ev_in[5] = 4'hC;
        tick();
        ev_in = '0;
        req(mk(2'b11, 5, 12, 1, 11));

        // Overflow keeps the older event.
        ev_in[2] = 4'h1;
        tick();
        ev_in = '0;
        tick();
        ev_in[2] = 4'h2;
        tick();
        ev_in = '0;
        chk("ovf_set", {26'd0, ovf}, 32'h04);
        req(mk(2'b01, 2, 1, 0, 0));
        chk("ovf_hold", {26'd0, ovf}, 32'h04);
        chk("ovf_drop", {26'd0, pending}, 32'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", {26'd0, ovf}, 32'd0);

        // Grant and new capture on the same channel in the same cycle.
        ev_in[1] = 4'h3;
        tick();
        ev_in = '0;
        chk("same_pend", {26'd0, pending}, 32'h02);
        sb.push_back(mk(2'b01, 1, 3, 0, 0));
        ev_in[1]    = 4'h7;
        frm.frm_req = 1'b1;
        tick();
        ev_in       = '0;
        frm.frm_req = 1'b0;
        chk("same_no_ovf", {26'd0, ovf}, 32'd0);
        chk("same_reload", {26'd0, pending}, 32'h02);
        req(mk(2'b01, 1, 7, 0, 0));

        // New overflow beats ovf_clr in the same cycle.
        ev_in[4] = 4'h9;
        tick();
        ev_in[4] = 4'hA;
        ovf_clr  = 1'b1;
        tick();
        ev_in   = '0;
        ovf_clr = 1'b0;
        chk("ovf_vs_clr", {26'd0, ovf}, 32'h10);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr2", {26'd0, ovf}, 32'd0);
        req(mk(2'b01, 4, 9, 0, 0));

        // Disabled channel drops its pending event and ignores captures.
        ev_in[0] = 4'h1;
        tick();
        ev_in = '0;
        chk("en_pend", {26'd0, pending}, 32'h01);
        ch_en = 6'h3E;
        tick();
        chk("en_clear", {26'd0, pending}, 32'd0);
        ev_in[0] = 4'h2;
        tick();
        ev_in = '0;
        chk("en_ignore", {26'd0, pending}, 32'd0);
        ch_en = 6'h3F;

`ifdef LTPI_I2C_SCHED_STATS_EN
        chk("gcnt1", {16'd0, grant_cnt[1]}, 32'd4);
        chk("gcnt3", {16'd0, grant_cnt[3]}, 32'd2);
        chk("ocnt4", {16'd0, ovf_cnt[4]}, 32'd0);
`endif

        // Link drop flushes pending and ignores events while down.
        ev_in[0] = 4'h1;
        ev_in[2] = 4'h2;
        ev_in[3] = 4'h3;
        ev_in[5] = 4'h5;
        tick();
        ev_in = '0;
        chk("drop_pend", {26'd0, pending}, 32'h2D);
        link_op  = 1'b0;
        ev_in[1] = 4'h6;
        tick();
        ev_in = '0;
        chk("drop_flush", {26'd0, pending}, 32'd0);
        link_op = 1'b1;
        req(mk(2'b00, 0, 0, 0, 0));
        chk("drop_idle", {26'd0, pending}, 32'd0);
        req(mk(2'b00, 0, 0, 0, 0));

        // Asynchronous reset mid-request: no frm_done, pointer back to 0.
        ev_in[2] = 4'h1;
        tick();
        ev_in = '0;
        chk("mid_pend", {26'd0, pending}, 32'h04);
        frm.frm_req = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_pend", {26'd0, pending}, 32'd0);
        frm.frm_req = 1'b0;
        tick();
        chk("mid_rst_done", {31'd0, frm.frm_done}, 32'd0);
        reset = 1'b0;
        tick();
        ev_in[1] = 4'hE;
        ev_in[4] = 4'hF;
        tick();
        ev_in = '0;
        req(mk(2'b11, 1, 14, 4, 15));

        tick();
        tick();
        tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
